boton_antirrebote: RTL and testbench

BOTON_ANTIRREBOTE -- requirements
Module: boton_antirrebote

---
 rtl/boton_antirrebote.sv | 174 +++++++++++++++++
 tb/tb_boton_antirrebote.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/boton_antirrebote.sv
// Two-key debouncer: synchronizes the select and start keys and emits one pulse per accepted press.
// Optional select auto-repeat is enabled by defining AUTOREPEAT_EN.
module boton_antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sel_n,
  input  logic btn_start_n,
  output logic selector,
  output logic start,
  output logic sel_held,
  output logic start_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {StIdle, StDbPress, StPressed, StDbRelease} key_state_e;

  logic [1:0] sel_sync_q, start_sync_q;
  logic       sel_pressed, start_pressed;

  key_state_e       sel_state_q, start_state_q;
  logic [CNT_W-1:0] sel_cnt_q, start_cnt_q;
  logic             sel_pulse_q, start_pulse_q;

  // Synchronizers reset to the released (high) raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync_q   <= 2'b11;
      start_sync_q <= 2'b11;
    end else begin
      sel_sync_q   <= {sel_sync_q[0], btn_sel_n};
      start_sync_q <= {start_sync_q[0], btn_start_n};
    end
  end

  assign sel_pressed   = ~sel_sync_q[1];
  assign start_pressed = ~start_sync_q[1];

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] sel_rep_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_state_q <= StIdle;
      sel_cnt_q   <= '0;
      sel_pulse_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      sel_rep_q   <= '0;
`endif
    end else begin
      sel_pulse_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      // Repeat count only survives while staying in StPressed.
      sel_rep_q   <= '0;
`endif
      case (sel_state_q)
        StIdle: begin
          if (sel_pressed) begin
            sel_state_q <= StDbPress;
            sel_cnt_q   <= CNT_ONE;
          end
        end
        StDbPress: begin
          if (!sel_pressed) begin
            sel_state_q <= StIdle;
            sel_cnt_q   <= '0;
          end else if (sel_cnt_q >= CNT_LAST) begin
            sel_state_q <= StPressed;
            sel_cnt_q   <= CNT_MAX;
            sel_pulse_q <= 1'b1;
          end else begin
            sel_cnt_q <= sel_cnt_q + CNT_ONE;
          end
        end
        StPressed: begin
          if (!sel_pressed) begin
            sel_state_q <= StDbRelease;
            sel_cnt_q   <= CNT_ONE;
          end
`ifdef AUTOREPEAT_EN
          else if (sel_rep_q == REP_LAST) begin
            sel_pulse_q <= 1'b1;
          end else begin
            sel_rep_q <= sel_rep_q + 1'b1;
          end
`endif
        end
        StDbRelease: begin
          if (sel_pressed) begin
            sel_state_q <= StPressed;
            sel_cnt_q   <= CNT_MAX;
          end else if (sel_cnt_q >= CNT_LAST) begin
            sel_state_q <= StIdle;
            sel_cnt_q   <= '0;
          end else begin
            sel_cnt_q <= sel_cnt_q + CNT_ONE;
          end
        end
        default: begin
          sel_state_q <= StIdle;
          sel_cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_state_q <= StIdle;
      start_cnt_q   <= '0;
      start_pulse_q <= 1'b0;
    end else begin
      start_pulse_q <= 1'b0;
      case (start_state_q)
        StIdle: begin
          if (start_pressed) begin
            start_state_q <= StDbPress;
            start_cnt_q   <= CNT_ONE;
          end
        end
        StDbPress: begin
          if (!start_pressed) begin
            start_state_q <= StIdle;
            start_cnt_q   <= '0;
          end else if (start_cnt_q >= CNT_LAST) begin
            start_state_q <= StPressed;
            start_cnt_q   <= CNT_MAX;
            start_pulse_q <= 1'b1;
          end else begin
            start_cnt_q <= start_cnt_q + CNT_ONE;
          end
        end
        StPressed: begin
          if (!start_pressed) begin
            start_state_q <= StDbRelease;
            start_cnt_q   <= CNT_ONE;
          end
        end
        StDbRelease: begin
          if (start_pressed) begin
            start_state_q <= StPressed;
            start_cnt_q   <= CNT_MAX;
          end else if (start_cnt_q >= CNT_LAST) begin
            start_state_q <= StIdle;
            start_cnt_q   <= '0;
          end else begin
            start_cnt_q <= start_cnt_q + CNT_ONE;
          end
        end
        default: begin
          start_state_q <= StIdle;
          start_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sel_held   = (sel_state_q == StPressed) || (sel_state_q == StDbRelease);
  assign start_held = (start_state_q == StPressed) || (start_state_q == StDbRelease);

  // Start wins a same-cycle collision and masks select while held.
  assign start    = start_pulse_q;
  assign selector = sel_pulse_q & ~start_pulse_q & ~start_held;

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for boton_antirrebote with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
module tb_boton_antirrebote;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_sel_n;
  logic btn_start_n;
  logic selector;
  logic start;
  logic sel_held;
  logic start_held;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  boton_antirrebote #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_sel_n  (btn_sel_n),
    .btn_start_n(btn_start_n),
    .selector   (selector),
    .start      (start),
    .sel_held   (sel_held),
    .start_held (start_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_sel_n   = 1'b1;
    btn_start_n = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    rst_n       = 1'b0;
    btn_sel_n   = 1'b1;
    btn_start_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_selector", 0, selector, 1'b0);
    chk("rst_start", 0, start, 1'b0);
    chk("rst_sel_held", 0, sel_held, 1'b0);
    chk("rst_start_held", 0, start_held, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Clean press: low for cycles 0..29.
    for (int t = 0; t < 42; t++) begin
      btn_sel_n = !(t < 30);
      #1;
      chk("clean_selector", t, selector, (t == 6) || (AR && t == 26));
      chk("clean_sel_held", t, sel_held, (t >= 6) && (t < 36));
      chk("clean_start", t, start, 1'b0);
      next_cycle();
    end
    idle(10);

    // Bounce: low 3, high 1, low 10.
    for (int t = 0; t < 26; t++) begin
      btn_sel_n = !((t < 3) || (t >= 4 && t < 14));
      #1;
      chk("bounce_selector", t, selector, t == 10);
      chk("bounce_sel_held", t, sel_held, (t >= 10) && (t < 20));
      next_cycle();
    end
    idle(10);

    // Simultaneous press, then ten select presses while start is held.
    for (int t = 0; t < 200; t++) begin
      btn_start_n = !(t < 180);
      if (t < 10)                       btn_sel_n = 1'b0;
      else if (t < 16)                  btn_sel_n = 1'b1;
      else if (t < 176)                 btn_sel_n = (((t - 16) % 16) >= 8);
      else                              btn_sel_n = 1'b1;
      #1;
      chk("simul_start", t, start, t == 6);
      chk("simul_selector", t, selector, 1'b0);
      chk("simul_start_held", t, start_held, (t >= 6) && (t < 186));
      if (t == 28) chk("simul_sel_fsm_runs", t, sel_held, 1'b1);
      next_cycle();
    end
    idle(10);

    // Reset asserted during cycles 4..7 of a select debounce, key held through.
    for (int t = 0; t < 34; t++) begin
      btn_sel_n = !(t < 22);
      rst_n     = !((t >= 4) && (t < 8));
      #1;
      chk("rstmid_selector", t, selector, t == 14);
      chk("rstmid_sel_held", t, sel_held, (t >= 14) && (t < 28));
      if (t >= 4 && t < 8) begin
        chk("rstmid_start", t, start, 1'b0);
        chk("rstmid_start_held", t, start_held, 1'b0);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    idle(10);

    // Long hold: 70 cycles.
    for (int t = 0; t < 82; t++) begin
      btn_sel_n = !(t < 70);
      #1;
      chk("repeat_selector", t, selector,
          (t == 6) || (AR && (t == 26 || t == 46 || t == 66)));
      chk("repeat_start", t, start, 1'b0);
      next_cycle();
    end
    idle(10);

    // One-cycle press glitch while debouncing the release.
    for (int t = 0; t < 26; t++) begin
      btn_sel_n = !((t < 10) || (t == 13));
      #1;
      chk("glitch_selector", t, selector, t == 6);
      chk("glitch_sel_held", t, sel_held, (t >= 6) && (t < 20));
      next_cycle();
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
